// File: rtl/call_manager_pkg.sv
// Shared encodings for the call-control engine: UI states, line states,
// outgoing command codes, application report codes and menu positions.
package call_manager_pkg;

  typedef enum logic [1:0] {
    UI_INIT    = 2'd0,
    UI_IDLE    = 2'd1,
    UI_DIALING = 2'd2,
    UI_CALL    = 2'd3
  } ui_st_e;

  typedef enum logic [2:0] {
    LN_FREE     = 3'd0,
    LN_OUTGOING = 3'd1,
    LN_RINGING  = 3'd2,
    LN_ACTIVE   = 3'd3,
    LN_HELD     = 3'd4,
    LN_ENDING   = 3'd5
  } line_st_e;

  // commands to the application layer
  localparam logic [2:0] CMD_DIAL   = 3'd1;
  localparam logic [2:0] CMD_ACCEPT = 3'd3;
  localparam logic [2:0] CMD_REJECT = 3'd4;
  localparam logic [2:0] CMD_HANGUP = 3'd5;
  localparam logic [2:0] CMD_HOLD   = 3'd7;

  // reports from the application layer
  localparam logic [2:0] INC_END       = 3'd0;
  localparam logic [2:0] INC_CONNECTED = 3'd2;
  localparam logic [2:0] INC_INCOMING  = 3'd6;

  // menu positions (meaning depends on the foreground line state)
  localparam logic [1:0] MENU_CALL = 2'd0;  // CALL / ACCEPT
  localparam logic [1:0] MENU_END  = 2'd1;  // END / REJECT
  localparam logic [1:0] MENU_HOLD = 2'd2;  // HOLD / SWAP

  // Step the three-entry menu forward (up) or backward (down), wrapping.
  function automatic logic [1:0] menu_step(input logic [1:0] m, input logic fwd);
    if (fwd) return (m == MENU_HOLD) ? MENU_CALL : m + 2'd1;
    return (m == MENU_CALL) ? MENU_HOLD : m - 2'd1;
  endfunction

endpackage

// File: rtl/call_manager_dial_buffer.sv
// Dialled-number shift register with digit count and an inactivity timer.
// The timer restarts on every accepted digit; expiry clears the number.
module dial_buffer #(
  parameter int DIGITS       = 4,
  parameter int DIAL_TIMEOUT = 1000
)(
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,     // start a fresh number
  input  logic                run,       // dialing in progress, timer counts
  input  logic                digit_en,  // valid BCD digit offered
  input  logic [3:0]          digit,
  output logic [4*DIGITS-1:0] phn_num,
  output logic                has_digit,
  output logic                expired
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam int TW = $clog2(DIAL_TIMEOUT);

  logic [CW-1:0] cnt;
  logic [TW-1:0] timer;
  logic          accept;

  // digits beyond capacity are dropped without touching the timer
  assign accept    = digit_en && (cnt < CW'(DIGITS));
  assign expired   = run && !accept && (timer == TW'(DIAL_TIMEOUT - 1));
  assign has_digit = (cnt != '0);

  // number, count and timer; expiry behaves like a clear
  always_ff @(posedge clk) begin
    if (!reset) begin
      phn_num <= '0;
      cnt     <= '0;
      timer   <= '0;
    end else if (clear || expired) begin
      phn_num <= '0;
      cnt     <= '0;
      timer   <= '0;
    end else if (accept) begin
      phn_num <= (phn_num << 4) | (4*DIGITS)'(digit);
      cnt     <= cnt + CW'(1);
      timer   <= '0;
    end else if (run) begin
      timer   <= timer + TW'(1);
    end
  end

endmodule

// File: rtl/call_manager.sv
// Multi-line call-control engine: UI state machine, per-line call state,
// foreground/free-line selection and a one-cycle registered command strobe.
module call_manager
  import call_manager_pkg::*;
#(
  parameter  int NUM_LINES    = 2,
  parameter  int DIGITS       = 4,
  parameter  int DIAL_TIMEOUT = 1000,
  localparam int LW           = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
)(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enter,
  input  logic                   up,
  input  logic                   down,
  input  logic                   digit_valid,
  input  logic [3:0]             digit,
  input  logic                   inc_valid,
  input  logic [2:0]             inc_command,
  input  logic [LW-1:0]          inc_line,
  output logic                   cmd_valid,
  output logic [2:0]             command,
  output logic [LW-1:0]          cmd_line,
  output logic [4*DIGITS-1:0]    phn_num,
  output logic [1:0]             ui_state,
  output logic [LW-1:0]          fg_line,
  output logic [1:0]             menu_item,
  output logic [3*NUM_LINES-1:0] line_state
);

  ui_st_e                     ui_q, ui_d, ui_nxt;
  logic [LW-1:0]              fg_q, fg_d;
  logic [1:0]                 menu_q, menu_d;
  logic [NUM_LINES-1:0][2:0]  line_q, line_d;

  logic                       iss;
  logic [2:0]                 iss_cmd;
  logic [LW-1:0]              iss_line;

  logic                       dial_clear, dial_run, digit_en, dial_fire;
  logic                       has_digit, dial_expired;

  logic                       inc_ok;
  logic [2:0]                 fg_st;
  logic                       free_any, park_any, busy_any;
  logic [LW-1:0]              free_idx, park_idx, busy_idx;

  assign inc_ok     = {1'b0, inc_line} < (LW+1)'(NUM_LINES);
  assign fg_st      = line_q[fg_q];
  assign ui_state   = ui_q;
  assign fg_line    = fg_q;
  assign menu_item  = menu_q;
  assign line_state = line_q;

  // lowest FREE line for a new dial, lowest waiting/held line for a swap
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    park_any = 1'b0;
    park_idx = '0;
    for (int i = NUM_LINES-1; i >= 0; i--) begin
      if (line_q[i] == LN_FREE) begin
        free_any = 1'b1;
        free_idx = LW'(i);
      end
      if ((LW'(i) != fg_q) && (line_q[i] == LN_RINGING || line_q[i] == LN_HELD)) begin
        park_any = 1'b1;
        park_idx = LW'(i);
      end
    end
  end

  // next UI/line state and command; reports take the whole cycle
  always_comb begin
    ui_d       = ui_q;
    fg_d       = fg_q;
    menu_d     = menu_q;
    line_d     = line_q;
    iss        = 1'b0;
    iss_cmd    = command;
    iss_line   = cmd_line;
    dial_clear = 1'b0;
    digit_en   = 1'b0;
    dial_fire  = 1'b0;
    busy_any   = 1'b0;
    busy_idx   = '0;

    if (inc_valid) begin
      if (inc_ok) begin
        case (inc_command)
          INC_INCOMING: begin
            if (line_q[inc_line] == LN_FREE) begin
              line_d[inc_line] = LN_RINGING;
              // only an idle UI jumps to the new call; otherwise it waits
              if (ui_q == UI_IDLE) begin
                fg_d   = inc_line;
                ui_d   = UI_CALL;
                menu_d = MENU_CALL;
              end
            end
          end
          INC_CONNECTED: begin
            // a held line asked to resume also comes back on CONNECTED
            if (line_q[inc_line] inside {LN_OUTGOING, LN_RINGING, LN_HELD})
              line_d[inc_line] = LN_ACTIVE;
          end
          INC_END:  line_d[inc_line] = LN_FREE;
          default: ;
        endcase
      end
    end else begin
      case (ui_q)
        UI_INIT: begin
          if (enter) ui_d = UI_IDLE;
        end
        UI_IDLE: begin
          if (enter) begin
            if (menu_q == MENU_CALL) begin
              ui_d       = UI_DIALING;
              dial_clear = 1'b1;
            end
          end else if (up) begin
            menu_d = menu_step(menu_q, 1'b1);
          end else if (down) begin
            menu_d = menu_step(menu_q, 1'b0);
          end
        end
        UI_DIALING: begin
          if (enter) begin
            if (has_digit && free_any) begin
              dial_fire        = 1'b1;
              line_d[free_idx] = LN_OUTGOING;
              fg_d             = free_idx;
              ui_d             = UI_CALL;
              menu_d           = MENU_CALL;
              iss              = 1'b1;
              iss_cmd          = CMD_DIAL;
              iss_line         = free_idx;
            end
          end else if (digit_valid && (digit <= 4'd9)) begin
            digit_en = 1'b1;
          end
        end
        UI_CALL: begin
          if (enter) begin
            case (menu_q)
              MENU_CALL: begin
                if (fg_st == LN_RINGING) begin
                  iss = 1'b1; iss_cmd = CMD_ACCEPT; iss_line = fg_q;
                end
              end
              MENU_END: begin
                if (fg_st == LN_RINGING) begin
                  iss = 1'b1; iss_cmd = CMD_REJECT; iss_line = fg_q;
                  line_d[fg_q] = LN_ENDING;
                end else if (fg_st == LN_ACTIVE || fg_st == LN_OUTGOING) begin
                  iss = 1'b1; iss_cmd = CMD_HANGUP; iss_line = fg_q;
                  line_d[fg_q] = LN_ENDING;
                end
              end
              MENU_HOLD: begin
                if (fg_st == LN_ACTIVE) begin
                  iss = 1'b1; iss_cmd = CMD_HOLD; iss_line = fg_q;
                  line_d[fg_q] = LN_HELD;
                  if (park_any) fg_d = park_idx;
                end else if (fg_st == LN_HELD) begin
                  // resume request; line stays HELD until CONNECTED
                  iss = 1'b1; iss_cmd = CMD_HOLD; iss_line = fg_q;
                end
              end
              default: ;
            endcase
          end else if (up) begin
            menu_d = menu_step(menu_q, 1'b1);
          end else if (down) begin
            menu_d = menu_step(menu_q, 1'b0);
          end
        end
        default: ;
      endcase
    end

    // in CALL: drop back to IDLE once every line is free, else keep fg on a live line
    if (ui_d == UI_CALL) begin
      for (int i = NUM_LINES-1; i >= 0; i--) begin
        if (line_d[i] != LN_FREE) begin
          busy_any = 1'b1;
          busy_idx = LW'(i);
        end
      end
      if (!busy_any) begin
        ui_d   = UI_IDLE;
        menu_d = MENU_CALL;
      end else if (line_d[fg_d] == LN_FREE) begin
        fg_d = busy_idx;
      end
    end
  end

  // timer stops on the cycle a number is dialled so it cannot race the dial
  assign dial_run = (ui_q == UI_DIALING) && !dial_fire;
  assign ui_nxt   = dial_expired ? UI_IDLE : ui_d;

  dial_buffer #(
    .DIGITS       (DIGITS),
    .DIAL_TIMEOUT (DIAL_TIMEOUT)
  ) u_dial (
    .clk       (clk),
    .reset     (reset),
    .clear     (dial_clear),
    .run       (dial_run),
    .digit_en  (digit_en),
    .digit     (digit),
    .phn_num   (phn_num),
    .has_digit (has_digit),
    .expired   (dial_expired)
  );

  // state and command registers; command/cmd_line hold their last value
  always_ff @(posedge clk) begin
    if (!reset) begin
      ui_q      <= UI_INIT;
      fg_q      <= '0;
      menu_q    <= MENU_CALL;
      line_q    <= '0;
      cmd_valid <= 1'b0;
      command   <= 3'd0;
      cmd_line  <= '0;
    end else begin
      ui_q      <= ui_nxt;
      fg_q      <= fg_d;
      menu_q    <= menu_d;
      line_q    <= line_d;
      cmd_valid <= iss;
      command   <= iss_cmd;
      cmd_line  <= iss_line;
    end
  end

endmodule

// File: tb/tb_call_manager.sv
// Randomised and directed bench for call_manager against a queue/array model.
module tb_call_manager;

  localparam int NL = 2;
  localparam int DG = 4;
  localparam int TO = 50;
  localparam int LW = 1;

  // reference encodings
  localparam int S_INIT = 0, S_IDLE = 1, S_DIAL = 2, S_CALL = 3;
  localparam int FREE = 0, OUTG = 1, RING = 2, ACT = 3, HELD = 4, ENDG = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enter = 1'b0, up = 1'b0, down = 1'b0, digit_valid = 1'b0, inc_valid = 1'b0;
  logic [3:0] digit = '0;
  logic [2:0] inc_command = '0;
  logic [LW-1:0] inc_line = '0;
  logic cmd_valid;
  logic [2:0] command;
  logic [LW-1:0] cmd_line;
  logic [4*DG-1:0] phn_num;
  logic [1:0] ui_state, menu_item;
  logic [LW-1:0] fg_line;
  logic [3*NL-1:0] line_state;

  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  call_manager #(.NUM_LINES(NL), .DIGITS(DG), .DIAL_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .enter(enter), .up(up), .down(down),
    .digit_valid(digit_valid), .digit(digit), .inc_valid(inc_valid),
    .inc_command(inc_command), .inc_line(inc_line), .cmd_valid(cmd_valid),
    .command(command), .cmd_line(cmd_line), .phn_num(phn_num), .ui_state(ui_state),
    .fg_line(fg_line), .menu_item(menu_item), .line_state(line_state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_ui, m_fg, m_menu, m_quiet;
  int m_ln[NL];
  int m_dig[$];
  bit m_cv;
  int m_cmd, m_cl;

  function automatic void model_reset();
    m_ui = S_INIT; m_fg = 0; m_menu = 0; m_quiet = 0;
    foreach (m_ln[i]) m_ln[i] = FREE;
    m_dig.delete();
    m_cv = 0; m_cmd = 0; m_cl = 0;
  endfunction

  function automatic int m_phn();
    int v = 0;
    foreach (m_dig[k]) v = v * 16 + m_dig[k];
    return v;
  endfunction

  function automatic int m_lines();
    int v = 0;
    for (int i = 0; i < NL; i++) v += m_ln[i] << (3 * i);
    return v;
  endfunction

  // lowest line (other than skip) whose state bit is set in mask, or -1
  function automatic int lowest(input int mask, input int skip);
    for (int i = 0; i < NL; i++)
      if (i != skip && mask[m_ln[i]]) return i;
    return -1;
  endfunction

  function automatic void issue(input int c, input int l);
    m_cv = 1; m_cmd = c; m_cl = l;
  endfunction

  function automatic void model_step(input bit rst, input bit e, input bit u, input bit d,
                                     input bit dv, input int dg, input bit iv,
                                     input int ic, input int il);
    bit counted;
    int s, f, b;
    if (rst) begin model_reset(); return; end
    m_cv = 0;
    counted = (m_ui == S_DIAL);
    if (iv) begin
      if (il < NL) begin
        if (ic == 6 && m_ln[il] == FREE) begin
          m_ln[il] = RING;
          if (m_ui == S_IDLE) begin m_fg = il; m_ui = S_CALL; m_menu = 0; end
        end else if (ic == 2 && m_ln[il] inside {OUTG, RING, HELD}) begin
          m_ln[il] = ACT;
        end else if (ic == 0) begin
          m_ln[il] = FREE;
        end
      end
    end else if (e) begin
      if (m_ui == S_INIT) m_ui = S_IDLE;
      else if (m_ui == S_IDLE) begin
        if (m_menu == 0) begin m_ui = S_DIAL; m_dig.delete(); m_quiet = 0; end
      end else if (m_ui == S_DIAL) begin
        f = lowest(1 << FREE, -1);
        if (m_dig.size() > 0 && f >= 0) begin
          m_ln[f] = OUTG; m_fg = f; m_ui = S_CALL; m_menu = 0;
          issue(1, f); counted = 0;
        end
      end else begin
        s = m_ln[m_fg];
        if (m_menu == 0 && s == RING) issue(3, m_fg);
        else if (m_menu == 1 && s == RING) begin issue(4, m_fg); m_ln[m_fg] = ENDG; end
        else if (m_menu == 1 && (s == ACT || s == OUTG)) begin issue(5, m_fg); m_ln[m_fg] = ENDG; end
        else if (m_menu == 2 && s == ACT) begin
          issue(7, m_fg); m_ln[m_fg] = HELD;
          f = lowest((1 << RING) | (1 << HELD), m_fg);
          if (f >= 0) m_fg = f;
        end else if (m_menu == 2 && s == HELD) issue(7, m_fg);
      end
    end else if ((u || d) && (m_ui == S_IDLE || m_ui == S_CALL)) begin
      m_menu = (m_menu + (u ? 1 : 2)) % 3;
    end else if (dv && dg <= 9 && m_ui == S_DIAL && m_dig.size() < DG) begin
      m_dig.push_back(dg); m_quiet = 0; counted = 0;
    end
    if (counted) begin
      m_quiet++;
      if (m_quiet == TO) begin m_ui = S_IDLE; m_dig.delete(); m_quiet = 0; end
    end
    if (m_ui == S_CALL) begin
      b = lowest(8'hFE, -1);
      if (b < 0) begin m_ui = S_IDLE; m_menu = 0; end
      else if (m_ln[m_fg] == FREE) m_fg = b;
    end
  endfunction

  task automatic check_all();
    chk("ui", ui_state, m_ui);
    chk("fg", fg_line, m_fg);
    chk("menu", menu_item, m_menu);
    chk("phn", phn_num, m_phn());
    chk("lines", line_state, m_lines());
    chk("cv", cmd_valid, m_cv);
    if (m_cv) begin
      chk("cmd", command, m_cmd);
      chk("cmd_line", cmd_line, m_cl);
    end
  endtask

  // one clock: drive at negedge, step model, check at the following negedge
  task automatic tick(input bit rst_n, input bit e, input bit u, input bit d, input bit dv,
                      input logic [3:0] dg, input bit iv, input logic [2:0] ic,
                      input logic [LW-1:0] il);
    reset = rst_n; enter = e; up = u; down = d; digit_valid = dv; digit = dg;
    inc_valid = iv; inc_command = ic; inc_line = il;
    model_step(!rst_n, e, u, d, dv, int'(dg), iv, int'(ic), int'(il));
    @(negedge clk);
    check_all();
    reset = 1'b1; enter = 0; up = 0; down = 0; digit_valid = 0; inc_valid = 0;
  endtask

  task automatic idle();             tick(1, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic press();            tick(1, 1, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic go_up();            tick(1, 0, 1, 0, 0, 0, 0, 0, 0); endtask
  task automatic go_down();          tick(1, 0, 0, 1, 0, 0, 0, 0, 0); endtask
  task automatic key(input logic [3:0] k); tick(1, 0, 0, 0, 1, k, 0, 0, 0); endtask
  task automatic rpt(input logic [2:0] c, input logic [LW-1:0] l); tick(1, 0, 0, 0, 0, 0, 1, c, l); endtask
  task automatic do_reset(); tick(0, 0, 0, 0, 0, 0, 0, 0, 0); tick(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask

  initial begin
    bit saw_cmd;
    int r;
    bit e, u, d, dv, iv;
    logic [3:0] dg;
    logic [2:0] ic;
    logic [LW-1:0] il;

    @(negedge clk);
    do_reset();
    chk("rst_ui", ui_state, 0);
    chk("rst_lines", line_state, 0);
    chk("rst_cmd", {cmd_valid, command, cmd_line}, 0);
    chk("rst_phn", phn_num, 0);

    press();
    chk("init_enter", ui_state, 1);

    // dial 5512
    press();
    key(5); key(5); key(1); key(2);
    press();
    chk("dial_cv", cmd_valid, 1);
    chk("dial_cmd", command, 1);
    chk("dial_line", cmd_line, 0);
    chk("dial_num", phn_num, 16'h5512);
    chk("dial_ui", ui_state, 3);
    idle();
    chk("dial_one_cycle", cmd_valid, 0);

    // call waiting, hold/swap, accept
    rpt(2, 0);
    rpt(6, 1);
    chk("wait_lines", line_state, 6'o23);
    chk("wait_fg", fg_line, 0);
    go_down();
    chk("menu_wrap_down", menu_item, 2);
    press();
    chk("hold_cmd", command, 7);
    chk("hold_line", cmd_line, 0);
    chk("hold_fg", fg_line, 1);
    chk("hold_lines", line_state, 6'o24);
    go_up();
    chk("menu_wrap_up", menu_item, 0);
    press();
    chk("acc_cmd", command, 3);
    chk("acc_line", cmd_line, 1);
    rpt(2, 1);
    chk("conn_lines", line_state, 6'o34);

    // both ends -> IDLE, menu reset
    go_down();
    rpt(0, 0);
    rpt(0, 1);
    chk("end_ui", ui_state, 1);
    chk("end_menu", menu_item, 0);

    // dial timeout
    press();
    key(7);
    saw_cmd = 0;
    for (int i = 0; i < TO - 1; i++) begin idle(); saw_cmd |= cmd_valid; end
    chk("to_before", ui_state, 2);
    idle(); saw_cmd |= cmd_valid;
    chk("to_ui", ui_state, 1);
    chk("to_phn", phn_num, 0);
    chk("to_nocmd", saw_cmd, 0);

    // enter dropped on a report cycle
    rpt(6, 0);
    tick(1, 1, 0, 0, 0, 0, 1, 3'd6, 1'b1);
    chk("drop_cv", cmd_valid, 0);
    chk("drop_lines", line_state, 6'o22);
    rpt(0, 0);
    rpt(0, 1);

    // overflow digits
    press();
    for (int k = 1; k <= 6; k++) key(4'(k));
    chk("ovf_phn", phn_num, 16'h1234);

    // reset mid-call
    press();
    rpt(2, 0);
    do_reset();
    chk("mid_rst_ui", ui_state, 0);
    chk("mid_rst_lines", line_state, 0);

    // randomised traffic
    for (int n = 0; n < 3000 && n_bad <= 20; n++) begin
      r = $urandom_range(0, 99);
      e = 0; u = 0; d = 0; dv = 0; iv = 0; dg = 0; ic = 0; il = 0;
      if (r == 99) begin
        for (int q = 0; q < TO + 5; q++) idle();
        continue;
      end
      if (r == 0) begin do_reset(); continue; end
      if (r < 31) ;
      else if (r < 46) e = 1;
      else if (r < 52) u = 1;
      else if (r < 58) d = 1;
      else if (r < 78) begin dv = 1; dg = 4'($urandom_range(0, 11)); end
      else begin
        iv = 1;
        r = $urandom_range(0, 9);
        ic = (r < 4) ? 3'd6 : (r < 7) ? 3'd2 : (r < 9) ? 3'd0 : 3'($urandom_range(0, 7));
        il = LW'($urandom_range(0, NL - 1));
        e = ($urandom_range(0, 3) == 0);
      end
      tick(1, e, u, d, dv, dg, iv, ic, il);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
